// File: rtl/board_reader.sv
// rtl/board_reader.sv - scans the 16x16 board and streams one classified cell per handshake
// Merges board RAM walls with frozen tank/projectile snapshots taken at frame start.
module board_reader (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] ram_address,
  input  logic [7:0] ram_q,
  input  logic [7:0] tank_1,
  input  logic [7:0] tank_2,
  input  logic [7:0] tank_1_proj,
  input  logic [7:0] tank_2_proj,
  input  logic [7:0] tank_1_dir,
  input  logic [7:0] tank_2_dir,
  input  logic [7:0] tank_1_proj_dir,
  input  logic [7:0] tank_2_proj_dir,
  output logic [7:0] cell_address,
  output logic [3:0] cell_code,
  output logic [7:0] cell_dir,
  output logic       cell_valid,
  input  logic       cell_ready
);

  localparam logic [3:0] CODE_EMPTY = 4'd0;
  localparam logic [3:0] CODE_WALL  = 4'd1;
  localparam logic [3:0] CODE_TANK1 = 4'd2;
  localparam logic [3:0] CODE_TANK2 = 4'd3;
  localparam logic [3:0] CODE_PROJ1 = 4'd4;
  localparam logic [3:0] CODE_PROJ2 = 4'd5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    EMIT    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] index;

  logic [7:0] snap_t1;
  logic [7:0] snap_t2;
  logic [7:0] snap_p1;
  logic [7:0] snap_p2;
  logic [7:0] snap_t1_dir;
  logic [7:0] snap_t2_dir;
  logic [7:0] snap_p1_dir;
  logic [7:0] snap_p2_dir;

  logic [3:0] class_code;
  logic [7:0] class_dir;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = CAPTURE;
      CAPTURE: state_next = EMIT;
      EMIT:    if (cell_ready) state_next = (index == 8'hFF) ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    cell_valid = 1'b0;
    frame_done = 1'b0;
    case (state)
      FETCH, CAPTURE: busy = 1'b1;
      EMIT: begin
        busy       = 1'b1;
        cell_valid = 1'b1;
      end
      DONE:    frame_done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // The scan index doubles as the RAM address, so it holds through EMIT stalls and idle.
  assign ram_address = index;

  // Earlier branches win: a projectile sitting on its tank shows as the tank.
  always_comb begin
    class_code = CODE_EMPTY;
    class_dir  = 8'h00;
    if (index == snap_t1) begin
      class_code = CODE_TANK1;
      class_dir  = snap_t1_dir;
    end else if (index == snap_t2) begin
      class_code = CODE_TANK2;
      class_dir  = snap_t2_dir;
    end else if (index == snap_p1) begin
      class_code = CODE_PROJ1;
      class_dir  = snap_p1_dir;
    end else if (index == snap_p2) begin
      class_code = CODE_PROJ2;
      class_dir  = snap_p2_dir;
    end else if (ram_q != 8'h00) begin
      class_code = CODE_WALL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index        <= 8'h00;
      cell_address <= 8'h00;
      cell_code    <= CODE_EMPTY;
      cell_dir     <= 8'h00;
      snap_t1      <= 8'h00;
      snap_t2      <= 8'h00;
      snap_p1      <= 8'h00;
      snap_p2      <= 8'h00;
      snap_t1_dir  <= 8'h00;
      snap_t2_dir  <= 8'h00;
      snap_p1_dir  <= 8'h00;
      snap_p2_dir  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            index       <= 8'h00;
            snap_t1     <= tank_1;
            snap_t2     <= tank_2;
            snap_p1     <= tank_1_proj;
            snap_p2     <= tank_2_proj;
            snap_t1_dir <= tank_1_dir;
            snap_t2_dir <= tank_2_dir;
            snap_p1_dir <= tank_1_proj_dir;
            snap_p2_dir <= tank_2_proj_dir;
          end
        end
        CAPTURE: begin
          cell_address <= index;
          cell_code    <= class_code;
          cell_dir     <= class_dir;
        end
        EMIT: begin
          if (cell_ready && (index != 8'hFF)) index <= index + 8'd1;
        end
        default: index <= index;
      endcase
    end
  end

endmodule

// File: tb/tb_board_reader.sv
// tb/tb_board_reader.sv - directed table-driven bench for board_reader
module tb_board_reader;

  logic       clk;
  logic       reset;
  logic       start;
  logic       busy;
  logic       frame_done;
  logic [7:0] ram_address;
  logic [7:0] ram_q;
  logic [7:0] tank_1, tank_2, tank_1_proj, tank_2_proj;
  logic [7:0] tank_1_dir, tank_2_dir, tank_1_proj_dir, tank_2_proj_dir;
  logic [7:0] cell_address;
  logic [3:0] cell_code;
  logic [7:0] cell_dir;
  logic       cell_valid;
  logic       cell_ready;

  board_reader dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
    .ram_address(ram_address), .ram_q(ram_q),
    .tank_1(tank_1), .tank_2(tank_2), .tank_1_proj(tank_1_proj), .tank_2_proj(tank_2_proj),
    .tank_1_dir(tank_1_dir), .tank_2_dir(tank_2_dir),
    .tank_1_proj_dir(tank_1_proj_dir), .tank_2_proj_dir(tank_2_proj_dir),
    .cell_address(cell_address), .cell_code(cell_code), .cell_dir(cell_dir),
    .cell_valid(cell_valid), .cell_ready(cell_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram [256];
  always @(posedge clk) ram_q <= ram[ram_address];

  typedef struct {
    logic [7:0]       t1, t2, p1, p2, d1, d2, dp1, dp2;
    logic [7:0]       wa0, wv0, wa1, wv1;
    logic [2:0][7:0]  ca;
    logic [2:0][3:0]  ec;
    logic [2:0][7:0]  ed;
  } vec_t;

  vec_t vecs [5];

  int tests;
  int failed;

  logic [3:0] code_arr [256];
  logic [7:0] dir_arr  [256];
  int first_valid, done_cyc, done_width, n_cells, order_err, stall_cnt, stall_err;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
  endtask

  task automatic apply_vec(input vec_t v);
    clear_ram();
    if (v.wv0 != 8'h00) ram[v.wa0] = v.wv0;
    if (v.wv1 != 8'h00) ram[v.wa1] = v.wv1;
    tank_1 = v.t1; tank_2 = v.t2; tank_1_proj = v.p1; tank_2_proj = v.p2;
    tank_1_dir = v.d1; tank_2_dir = v.d2; tank_1_proj_dir = v.dp1; tank_2_proj_dir = v.dp2;
  endtask

  // Pulses start, then handshakes every cell until frame_done ends; optional stall and mid-frame tank_1 move.
  task automatic run_frame(input int stall_addr, input int stall_len, input int change_addr);
    int cyc;
    bit fin;
    logic [3:0] h_c;
    logic [7:0] h_d, h_r;
    first_valid = -1; done_cyc = -1; done_width = 0; n_cells = 0;
    order_err = 0; stall_cnt = 0; stall_err = 0; fin = 1'b0;
    h_c = 4'h0; h_d = 8'h00; h_r = 8'h00;
    for (int i = 0; i < 256; i++) begin code_arr[i] = 4'hF; dir_arr[i] = 8'hEE; end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    while (!fin && cyc < 3000) begin
      cell_ready = 1'b1;
      if (cell_valid && first_valid < 0) first_valid = cyc;
      if (cell_valid && int'(cell_address) == stall_addr) begin
        if (stall_cnt == 0) begin
          h_c = cell_code; h_d = cell_dir; h_r = ram_address;
        end else if (cell_code !== h_c || cell_dir !== h_d || ram_address !== h_r) begin
          stall_err++;
        end
        if (stall_cnt < stall_len) begin
          cell_ready = 1'b0;
          stall_cnt++;
        end
      end
      if (frame_done) begin
        if (done_cyc < 0) done_cyc = cyc;
        done_width++;
      end else if (done_cyc >= 0) begin
        fin = 1'b1;
      end
      if (cell_valid && cell_ready) begin
        if (cell_address != n_cells[7:0]) order_err++;
        code_arr[cell_address] = cell_code;
        dir_arr[cell_address]  = cell_dir;
        if (int'(cell_address) == change_addr) tank_1 = 8'h06;
        n_cells++;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int others;
    int k;
    int mon;
    tests = 0; failed = 0;
    reset = 1'b1; start = 1'b0; cell_ready = 1'b1;
    clear_ram();

    vecs[0] = '{t1:8'h00, t2:8'hFF, p1:8'h00, p2:8'hFF, d1:8'h01, d2:8'h00, dp1:8'h01, dp2:8'h00,
                wa0:8'h00, wv0:8'h00, wa1:8'h00, wv1:8'h00,
                ca:{8'h00, 8'hFF, 8'h80}, ec:{4'd2, 4'd3, 4'd0}, ed:{8'h01, 8'h00, 8'h00}};
    vecs[1] = '{t1:8'h00, t2:8'hFF, p1:8'h00, p2:8'hFF, d1:8'h01, d2:8'h00, dp1:8'h01, dp2:8'h00,
                wa0:8'h37, wv0:8'h01, wa1:8'h38, wv1:8'h05,
                ca:{8'h37, 8'h38, 8'h36}, ec:{4'd1, 4'd1, 4'd0}, ed:{8'h00, 8'h00, 8'h00}};
    vecs[2] = '{t1:8'h22, t2:8'hFF, p1:8'h22, p2:8'h22, d1:8'h03, d2:8'h01, dp1:8'h07, dp2:8'h01,
                wa0:8'h22, wv0:8'h01, wa1:8'h00, wv1:8'h00,
                ca:{8'h22, 8'h23, 8'hFF}, ec:{4'd2, 4'd0, 4'd3}, ed:{8'h03, 8'h00, 8'h01}};
    vecs[3] = '{t1:8'h00, t2:8'hFF, p1:8'h10, p2:8'h40, d1:8'h01, d2:8'h00, dp1:8'h03, dp2:8'h07,
                wa0:8'h40, wv0:8'h01, wa1:8'h00, wv1:8'h00,
                ca:{8'h40, 8'h10, 8'h41}, ec:{4'd5, 4'd4, 4'd0}, ed:{8'h07, 8'h03, 8'h00}};
    vecs[4] = '{t1:8'h70, t2:8'h50, p1:8'h50, p2:8'hFF, d1:8'h03, d2:8'h07, dp1:8'h01, dp2:8'h00,
                wa0:8'h60, wv0:8'h80, wa1:8'h00, wv1:8'h00,
                ca:{8'h50, 8'h60, 8'h70}, ec:{4'd3, 4'd1, 4'd2}, ed:{8'h07, 8'h00, 8'h03}};

    apply_vec(vecs[0]);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset busy", busy, 0);
    check("reset frame_done", frame_done, 0);
    check("reset ram_address", ram_address, 8'h00);
    check("reset cell_valid", cell_valid, 0);
    check("reset cell_address", cell_address, 8'h00);
    check("reset cell_code", cell_code, 0);
    check("reset cell_dir", cell_dir, 8'h00);

    for (int v = 0; v < 5; v++) begin
      apply_vec(vecs[v]);
      run_frame(-1, 0, -1);
      check($sformatf("v%0d cell count", v), n_cells, 256);
      check($sformatf("v%0d order errors", v), order_err, 0);
      for (int j = 0; j < 3; j++) begin
        check($sformatf("v%0d cell %02h code", v, vecs[v].ca[j]), code_arr[vecs[v].ca[j]], vecs[v].ec[j]);
        check($sformatf("v%0d cell %02h dir", v, vecs[v].ca[j]), dir_arr[vecs[v].ca[j]], vecs[v].ed[j]);
      end
      if (v == 0) begin
        others = 0;
        for (int i = 1; i < 255; i++) if (code_arr[i] != 4'd0) others++;
        check("v0 nonempty interior cells", others, 0);
        check("v0 first valid cycle", first_valid, 3);
        check("v0 frame_done cycle", done_cyc, 769);
        check("v0 frame_done width", done_width, 1);
        check("v0 busy after frame", busy, 0);
      end
      if (v == 1) begin
        check("v1 cell 39 code", code_arr[8'h39], 0);
      end
    end

    apply_vec(vecs[0]);
    run_frame(8'h10, 5, -1);
    check("stall cycles", stall_cnt, 5);
    check("stall output changes", stall_err, 0);
    check("stall cell count", n_cells, 256);
    check("stall order errors", order_err, 0);
    check("stall frame_done cycle", done_cyc, 774);

    clear_ram();
    tank_1 = 8'h05; tank_1_dir = 8'h01; tank_2 = 8'hFF; tank_2_dir = 8'h00;
    tank_1_proj = 8'hFF; tank_2_proj = 8'hFF;
    run_frame(-1, 0, 2);
    check("frozen cell 05 code", code_arr[8'h05], 2);
    check("frozen cell 06 code", code_arr[8'h06], 0);
    run_frame(-1, 0, -1);
    check("resample cell 06 code", code_arr[8'h06], 2);
    check("resample cell 06 dir", dir_arr[8'h06], 8'h01);
    check("resample cell 05 code", code_arr[8'h05], 0);

    apply_vec(vecs[0]);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(cell_valid && cell_address == 8'h80) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("reached cell 80 valid", cell_valid, 1);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("midreset cell_valid", cell_valid, 0);
    check("midreset busy", busy, 0);
    check("midreset frame_done", frame_done, 0);
    check("midreset cell_address", cell_address, 8'h00);
    check("midreset ram_address", ram_address, 8'h00);
    mon = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || frame_done || cell_valid) mon++;
    end
    check("start during reset ignored", mon, 0);
    run_frame(-1, 0, -1);
    check("restart cell count", n_cells, 256);
    check("restart order errors", order_err, 0);
    check("restart first valid cycle", first_valid, 3);
    check("restart cell 00 code", code_arr[8'h00], 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/board_reader.md
# board_reader

Read-side counterpart of the game storage block. On a start pulse it scans all 256 board cells in address order. For each cell it fetches the wall entry from the board RAM read port and merges it with snapshots of the tank and projectile position/direction registers. It then streams one classified cell per valid/ready handshake to the VGA tile drawer.

## Interface
- Parameters: none. Grid is fixed at 16x16 by the 8-bit cell address: high nibble is the column, low nibble is the row.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a frame scan when idle
- busy  out  1  high from the cycle after an accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the last cell handshake
- ram_address  out  8  board RAM read address
- ram_q  in  8  wall data; valid one cycle after ram_address (0 = no wall, nonzero = wall)
- tank_1, tank_2, tank_1_proj, tank_2_proj  in  8 each  object positions
- tank_1_dir, tank_2_dir, tank_1_proj_dir, tank_2_proj_dir  in  8 each  direction codes (up 0x00, down 0x01, left 0x03, right 0x07)
- cell_address  out  8  address of the presented cell
- cell_code  out  4  0 empty, 1 wall, 2 tank1, 3 tank2, 4 proj1, 5 proj2
- cell_dir  out  8  direction of the occupying object; 0x00 for empty or wall
- cell_valid  out  1  cell_* outputs are valid
- cell_ready  in  1  drawer accepts the cell

## Operation
- FSM states: IDLE, FETCH, CAPTURE, EMIT, DONE.
- IDLE:
  - start=1 loads index to 0x00.
  - Snapshots all eight position/direction inputs into internal registers.
  - Moves to FETCH.
- FETCH: ram_address = index. Always moves to CAPTURE.
- CAPTURE:
  - Samples ram_q.
  - Classifies the cell against the snapshots.
  - Registers cell_address = index, cell_code and cell_dir.
  - Moves to EMIT.
- EMIT:
  - cell_valid=1.
  - Holds until cell_valid & cell_ready.
  - On the handshake: if index==0xFF go to DONE, else index+1 and go to FETCH.
- DONE: frame_done=1 for exactly one cycle, busy drops, go to IDLE.
- Classification priority: tank1 > tank2 > proj1 > proj2 > wall > empty.
  - A projectile sitting in its tank (same address) shows as the tank.
  - Any nonzero ram_q counts as a wall.
- cell_dir takes the snapshot direction of the winning object.
- Scan order is linear 0x00..0xFF (row varies fastest). The 8-bit index wraps only at frame end.
- Snapshots are frozen for the whole frame, so input changes mid-frame are ignored. The next start re-samples them.
- start while busy is ignored.
- ram_address holds index in every non-IDLE state and holds its last value in IDLE.
- The block never writes the RAM and has no write-enable output.

## Timing
- Reset values: busy 0, frame_done 0, ram_address 0x00, cell_valid 0, cell_address 0x00, cell_code 0, cell_dir 0x00. FSM enters IDLE and index is 0.
- Reset mid-frame: on the next edge all outputs take their reset values. No frame_done pulse; the partial frame is abandoned.
- Start at edge N. Then:
  - FETCH during cycle N+1 (ram_address=0x00).
  - CAPTURE during N+2.
  - cell_valid first high in cycle N+3.
- Throughput with cell_ready held high: one cell per 3 cycles.
- A full frame is 768 cycles from start to the last handshake, and frame_done is high the following cycle.
- While cell_valid=1 and cell_ready=0, cell_address, cell_code and cell_dir are stable and ram_address is unchanged.
- cell_valid falls the cycle after the handshake, so no cell repeats or is skipped.
- reset has priority over start in the same cycle.

## Test plan
- Reset with tank_1=tank_1_proj=0x00 (dirs 0x01), tank_2=tank_2_proj=0xFF (dirs 0x00), RAM all 0, ready=1, then start. Required:
  - 256 cells in order.
  - Cell 0x00 is code 2, dir 0x01. Cell 0xFF is code 3, dir 0x00. All others are code 0.
  - First valid at start+3. frame_done 769 cycles after start, one cycle wide.
- RAM[0x37]=1, RAM[0x38]=5 -> cells 0x37 and 0x38 are code 1, dir 0x00. Neighbours are code 0.
- Hold ready=0 for 5 cycles while cell 0x10 is valid -> outputs constant, ram_address constant, then exactly one handshake and the next cell is 0x11.
- Overlaps:
  - tank_1=tank_1_proj=tank_2_proj=0x22 with RAM[0x22]=1 -> code 2.
  - tank_2_proj=0x40 (dir 0x07) with RAM[0x40]=1 -> code 5, dir 0x07.
- tank_1 at 0x05 at start, changed to 0x06 after cell 0x02 handshakes -> cell 0x05 is code 2, cell 0x06 is code 0. A second start shows 0x06 as code 2.
- Assert reset while cell 0x80 is valid -> next cycle valid=0, busy=0, no frame_done. A start pulsed in the same cycle as reset is ignored. A later start restarts at 0x00.
